// File: rtl/time_scan_pkg.sv
`timescale 1ns/1ps
// Shared codes and digit-enable patterns for the time scan display path.
// Latency: n/a (constants only).
// Backpressure: n/a.
package time_scan_pkg;
  // Symbol codes understood by the downstream 14-segment decoder
  localparam logic [3:0] BCD_A     = 4'd10;
  localparam logic [3:0] BCD_P     = 4'd11;
  localparam logic [3:0] BCD_M     = 4'd12;
  localparam logic [3:0] BCD_BLANK = 4'd15;

  // Active-low digit enables, one digit lit at a time
  localparam logic [3:0] DIG0    = 4'b1110;
  localparam logic [3:0] DIG1    = 4'b1101;
  localparam logic [3:0] DIG2    = 4'b1011;
  localparam logic [3:0] DIG3    = 4'b0111;
  localparam logic [3:0] DIG_OFF = 4'b1111;
endpackage

// File: rtl/bcd_mod_counter.sv
`timescale 1ns/1ps
// Two-digit BCD counter modulo MOD (MOD <= 100), used for seconds and minutes.
// Latency: new count one cycle after i_inc; o_carry is combinational with i_inc at MOD-1.
// Backpressure: none; i_clr wins over i_inc and suppresses carry.
module bcd_mod_counter #(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inc,
  input  logic       i_clr,
  output logic       o_carry,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);
  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic       w_at_max;

  assign w_at_max = (r_tens == 4'((MOD - 1) / 10)) && (r_ones == 4'((MOD - 1) % 10));
  assign o_carry  = i_inc & ~i_clr & w_at_max;
  assign o_tens   = r_tens;
  assign o_ones   = r_ones;

  // Count in BCD, wrapping to 00 after MOD-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (i_clr) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (i_inc) begin
      if (w_at_max) begin
        r_tens <= 4'd0;
        r_ones <= 4'd0;
      end else if (r_ones == 4'd9) begin
        r_ones <= 4'd0;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end
endmodule

// File: rtl/time_scan_ctrl.sv
`timescale 1ns/1ps
// 12-hour clock (h:m:s + AM/PM) driving a 4-digit scan multiplexer.
// Latency: bcd/ssd_ctl registered one cycle after index/time change; time updates with sec_tick.
// Backpressure: none. Optional TIME_SCAN_BLINK_EN blanks digits in the second half-second of set mode.
module time_scan_ctrl
  import time_scan_pkg::*;
#(
  parameter int SEC_DIV  = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_set_en,
  input  logic       i_hr_inc,
  input  logic       i_min_inc,
  input  logic       i_show_ampm,
  output logic [3:0] o_bcd,
  output logic [3:0] o_ssd_ctl,
  output logic       o_pm,
  output logic       o_sec_tick
);
  localparam int SEC_W  = $clog2(SEC_DIV);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SEC_W-1:0]  r_presc;
  logic [SCAN_W-1:0] r_scan;
  logic [1:0]        r_idx;
  logic [3:0]        r_hour;
  logic              r_pm;
  logic              r_sec_tick;
  logic [3:0]        r_bcd;
  logic [3:0]        r_ssd;

  logic       w_tick;
  logic       w_sec_carry;
  logic       w_min_carry;
  logic       w_min_step;
  logic       w_hr_step;
  logic [3:0] w_sec_tens, w_sec_ones;
  logic [3:0] w_min_tens, w_min_ones;
  logic [3:0] w_hr_tens, w_hr_ones;
  logic [3:0] w_bcd_nxt;
  logic [3:0] w_ssd_nxt;
  logic       w_unused_sec;

  assign w_tick     = (r_presc == SEC_W'(SEC_DIV - 1));
  // Run mode chains carries; set mode takes the pulses and never carries min->hour
  assign w_min_step = i_set_en ? i_min_inc : w_sec_carry;
  assign w_hr_step  = i_set_en ? i_hr_inc  : w_min_carry;
  assign w_hr_tens  = (r_hour >= 4'd10) ? 4'd1 : 4'd0;
  assign w_hr_ones  = (r_hour >= 4'd10) ? (r_hour - 4'd10) : r_hour;
  // Seconds digits are not displayed; only their carry matters
  assign w_unused_sec = ^{w_sec_tens, w_sec_ones};

  bcd_mod_counter #(.MOD(60)) u_sec (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_tick & ~i_set_en),
    .i_clr   (i_set_en),
    .o_carry (w_sec_carry),
    .o_tens  (w_sec_tens),
    .o_ones  (w_sec_ones)
  );

  bcd_mod_counter #(.MOD(60)) u_min (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_min_step),
    .i_clr   (1'b0),
    .o_carry (w_min_carry),
    .o_tens  (w_min_tens),
    .o_ones  (w_min_ones)
  );

  // Free-running one-second prescaler and registered tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc    <= '0;
      r_sec_tick <= 1'b0;
    end else begin
      r_sec_tick <= w_tick;
      r_presc    <= w_tick ? '0 : r_presc + SEC_W'(1);
    end
  end

  // Hour 1..12; pm flips only on the 11->12 step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hour <= 4'd12;
      r_pm   <= 1'b0;
    end else if (w_hr_step) begin
      if (r_hour == 4'd12) begin
        r_hour <= 4'd1;
      end else begin
        r_hour <= r_hour + 4'd1;
        if (r_hour == 4'd11) r_pm <= ~r_pm;
      end
    end
  end

  // Scan slot timer and digit index 0->1->2->3->0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan <= '0;
      r_idx  <= 2'd0;
    end else if (r_scan == SCAN_W'(SCAN_DIV - 1)) begin
      r_scan <= '0;
      r_idx  <= r_idx + 2'd1;
    end else begin
      r_scan <= r_scan + SCAN_W'(1);
    end
  end

  // Select code and digit enable for the current index
  always_comb begin
    w_bcd_nxt = BCD_BLANK;
    w_ssd_nxt = DIG_OFF;
    case (r_idx)
      2'd0: begin
        w_ssd_nxt = DIG0;
        w_bcd_nxt = i_show_ampm ? BCD_BLANK : w_min_ones;
      end
      2'd1: begin
        w_ssd_nxt = DIG1;
        w_bcd_nxt = i_show_ampm ? BCD_BLANK : w_min_tens;
      end
      2'd2: begin
        w_ssd_nxt = DIG2;
        w_bcd_nxt = i_show_ampm ? BCD_M : w_hr_ones;
      end
      default: begin
        w_ssd_nxt = DIG3;
        if (i_show_ampm)           w_bcd_nxt = r_pm ? BCD_P : BCD_A;
        else if (r_hour < 4'd10)   w_bcd_nxt = BCD_BLANK;
        else                       w_bcd_nxt = w_hr_tens;
      end
    endcase
`ifdef TIME_SCAN_BLINK_EN
    if (i_set_en && (r_presc >= SEC_W'(SEC_DIV / 2))) w_ssd_nxt = DIG_OFF;
`endif
  end

  // Register display outputs every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd <= BCD_BLANK;
      r_ssd <= DIG_OFF;
    end else begin
      r_bcd <= w_bcd_nxt;
      r_ssd <= w_ssd_nxt;
    end
  end

  assign o_bcd      = r_bcd;
  assign o_ssd_ctl  = r_ssd;
  assign o_pm       = r_pm;
  assign o_sec_tick = r_sec_tick;
endmodule
